// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N     = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Snapshot of the arbiter's internal state, exported for observation.
  typedef struct packed {
    logic [0:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] owner;
    logic [3:0]       hold_cnt;
  } arb_dbg_t;

  function automatic logic [N-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side bundle between the requesters and the arbiter driving mux_8_1.
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;

  // req[i] is a level request held by requester i; gnt/sel/sel_valid are
  // registered and update one edge after req. While sel_valid is 1, gnt is
  // one-hot, sel is the index of its set bit, and Y of the mux carries I[sel].
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;

  modport master (output req, input gnt, input sel, input sel_valid);
  modport slave  (input req, output gnt, output sel, output sel_valid);

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Circular priority encoder: first set bit of req scanning from start upward, modulo 8.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_start,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_pos;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    o_idx = '0;
    w_pos = '0;
    o_any = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      w_pos = i_start + SEL_W'(i);
      if (i_req[w_pos]) o_idx = w_pos;
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 mux, with a bounded hold per owner.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux8_rr_arbiter_if.slave     bus,
  output arb_dbg_t             o_dbg
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_owner;
  logic [3:0]       r_hold;
  logic [N-1:0]     r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_sel_valid;

  logic [N-1:0]     w_req_oth;
  logic [N-1:0]     w_pick_req;
  logic [SEL_W-1:0] w_pick_start;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_release;
  logic             w_preempt;

  assign w_req_oth = bus.req & ~onehot8(r_owner);
  assign w_release = ~bus.req[r_owner];
  assign w_preempt = bus.req[r_owner] && (r_hold >= HOLD_MAX) && (|w_req_oth);

  // One encoder serves both states: fresh pick from ptr when idle,
  // handover search just past the owner when granting.
  assign w_pick_req   = (r_state == ST_GRANT) ? w_req_oth : bus.req;
  assign w_pick_start = (r_state == ST_GRANT) ? r_owner + 3'd1 : r_ptr;

  rr_pick8 u_pick (
    .i_req   (w_pick_req),
    .i_start (w_pick_start),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_hold      <= '0;
      r_gnt       <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_any) begin
        r_owner     <= w_idx;
        r_gnt       <= onehot8(w_idx);
        r_sel       <= w_idx;
        r_sel_valid <= 1'b1;
        r_hold      <= 4'd1;
        r_state     <= ST_GRANT;
      end
    end else begin
      if (w_release || w_preempt) begin
        r_ptr <= r_owner + 3'd1;
        if (w_any) begin
          r_owner <= w_idx;
          r_gnt   <= onehot8(w_idx);
          r_sel   <= w_idx;
          r_hold  <= 4'd1;
        end else begin
          r_gnt       <= '0;
          r_sel_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      end else if (r_hold < HOLD_MAX) begin
        r_hold <= r_hold + 4'd1;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.sel_valid = r_sel_valid;

  always_comb begin
    o_dbg          = '0;
    o_dbg.state    = r_state;
    o_dbg.ptr      = r_ptr;
    o_dbg.owner    = r_owner;
    o_dbg.hold_cnt = r_hold;
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_mux8_rr_arbiter;
  import mux8_arb_pkg::*;

  localparam int MH4 = 4;
  localparam int MH1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  arb_dbg_t dbg4, dbg1;

  mux8_rr_arbiter_if bus4 ();
  mux8_rr_arbiter_if bus1 ();

  mux8_rr_arbiter #(.MAX_HOLD(MH4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .o_dbg(dbg4));
  mux8_rr_arbiter #(.MAX_HOLD(MH1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .o_dbg(dbg1));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters and check helper ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Model keeps "who owns the mux and for how long" as plain integers per DUT.
  int m_busy[2], m_owner[2], m_hold[2], m_ptr[2], m_sel[2];
  int mh[2] = '{MH4, MH1};
  logic [11:0] exp_q[$];
  logic [11:0] exp_q1[$];

  function automatic int pick(input logic [7:0] r, input int start);
    for (int i = 0; i < 8; i++) begin
      int p;
      p = (start + i) % 8;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [11:0] model_step(input int d, input logic [7:0] r);
    logic [7:0] others;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    int k;
    if (m_busy[d] != 0) begin
      k = m_owner[d];
      others = r;
      others[k] = 1'b0;
      if (r[k] == 1'b0 || (m_hold[d] >= mh[d] && others != 8'h00)) begin
        m_ptr[d] = (k + 1) % 8;
        if (others != 8'h00) begin
          m_owner[d] = pick(others, k + 1);
          m_sel[d]   = m_owner[d];
          m_hold[d]  = 1;
        end else begin
          m_busy[d] = 0;
        end
      end else if (m_hold[d] < mh[d]) begin
        m_hold[d]++;
      end
    end else if (r != 8'h00) begin
      m_owner[d] = pick(r, m_ptr[d]);
      m_sel[d]   = m_owner[d];
      m_busy[d]  = 1;
      m_hold[d]  = 1;
    end
    g = (m_busy[d] != 0) ? (8'h01 << m_owner[d]) : 8'h00;
    s = 3'(m_sel[d]);
    v = (m_busy[d] != 0);
    return {g, s, v};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          m_busy[d] = 0; m_owner[d] = 0; m_hold[d] = 0; m_ptr[d] = 0; m_sel[d] = 0;
        end
        exp_q.delete();
        exp_q1.delete();
      end else begin
        exp_q.push_back(model_step(0, bus4.req));
        exp_q1.push_back(model_step(1, bus1.req));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int w4[8];
  int w1[8];

  task automatic score(input string tag, input logic [7:0] g, input logic [2:0] s,
                       input logic v, input int have, input logic [11:0] e);
    if (have == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: got output with no expected entry", tag);
    end else begin
      chk({tag, "_sb"}, {20'd0, g, s, v}, {20'd0, e});
    end
    chk({tag, "_onehot"}, 32'($onehot0(g)), 32'd1);
    chk({tag, "_selidx"}, {24'd0, g}, {24'd0, (v ? (8'h01 << s) : 8'h00)});
  endtask

  initial begin
    logic [11:0] e;
    int have, worst;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        #1;
        have = exp_q.size();
        e = (have != 0) ? exp_q.pop_front() : 12'h0;
        score("d4", bus4.gnt, bus4.sel, bus4.sel_valid, have, e);
        have = exp_q1.size();
        e = (have != 0) ? exp_q1.pop_front() : 12'h0;
        score("d1", bus1.gnt, bus1.sel, bus1.sel_valid, have, e);
        worst = 0;
        for (int i = 0; i < 8; i++) begin
          if (bus4.req[i] && !bus4.gnt[i]) w4[i]++; else w4[i] = 0;
          if (w4[i] > worst) worst = w4[i];
        end
        chk("d4_fair", 32'(worst > 7 * MH4 + 1), 32'd0);
        worst = 0;
        for (int i = 0; i < 8; i++) begin
          if (bus1.req[i] && !bus1.gnt[i]) w1[i]++; else w1[i] = 0;
          if (w1[i] > worst) worst = w1[i];
        end
        chk("d1_fair", 32'(worst > 7 * MH1 + 1), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic dir4(input string name, input logic [7:0] g, input logic [2:0] s, input logic v);
    chk({name, "_gnt"}, {24'd0, bus4.gnt}, {24'd0, g});
    chk({name, "_sel"}, {29'd0, bus4.sel}, {29'd0, s});
    chk({name, "_sv"},  {31'd0, bus4.sel_valid}, {31'd0, v});
  endtask

  task automatic reset_to(input logic [7:0] r4, input logic [7:0] r1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus4.req = r4;
    bus1.req = r1;
    rst_n = 1'b1;
  endtask

  logic [7:0] mux_in;
  logic       y;
  assign y = mux_in[bus4.sel];

  // ---------------- stimulus ----------------
  initial begin
    mux_in   = 8'h20;
    bus4.req = 8'h00;
    bus1.req = 8'h00;
    repeat (3) @(negedge clk);
    dir4("rst", 8'h00, 3'd0, 1'b0);
    chk("rst_dbg4", {17'd0, dbg4}, 32'd0);
    chk("rst_dbg1", {17'd0, dbg1}, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dir4("idle", 8'h00, 3'd0, 1'b0);
    end

    // Single requester: grant one cycle later, held with hold saturating.
    bus4.req = 8'h04;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      dir4("single", 8'h04, 3'd2, 1'b1);
    end
    chk("single_hold_sat", {28'd0, dbg4.hold_cnt}, MH4);
    bus4.req = 8'h00;
    @(negedge clk);
    dir4("single_drop", 8'h00, 3'd2, 1'b0);

    // Two requesters alternating every MAX_HOLD cycles from reset.
    reset_to(8'h81, 8'h00);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 4)      dir4("preempt_a", 8'h01, 3'd0, 1'b1);
      else if (c < 8) dir4("preempt_b", 8'h80, 3'd7, 1'b1);
      else            dir4("preempt_c", 8'h01, 3'd0, 1'b1);
    end

    // Owner 5 leaves as 6 and 1 arrive: handover without an idle cycle.
    bus4.req = 8'h00;
    @(negedge clk);
    bus4.req = 8'h20;
    repeat (3) begin
      @(negedge clk);
      dir4("own5", 8'h20, 3'd5, 1'b1);
    end
    bus4.req = 8'h42;
    @(negedge clk);
    dir4("handover", 8'h40, 3'd6, 1'b1);

    // Async reset in the middle of a grant to owner 3.
    bus4.req = 8'h08;
    @(negedge clk);
    dir4("own3", 8'h08, 3'd3, 1'b1);
    #2 rst_n = 1'b0;
    #1 dir4("async_rst", 8'h00, 3'd0, 1'b0);
    chk("async_rst_state", {31'd0, dbg4.state}, {31'd0, ST_IDLE});

    // MAX_HOLD=1 with everyone requesting: pure rotation.
    repeat (2) @(negedge clk);
    bus4.req = 8'h00;
    bus1.req = 8'hFF;
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("rot_sel", {29'd0, bus1.sel}, 32'(c % 8));
      chk("rot_gnt", {24'd0, bus1.gnt}, 32'(8'h01 << (c % 8)));
    end

    // Mux pairing: only I5 is high, so Y follows the grant to requester 5.
    @(negedge clk);
    chk("mux_idle", {31'd0, y & bus4.sel_valid}, 32'd0);
    bus4.req = 8'h20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mux_y", {31'd0, y & bus4.sel_valid}, 32'd1);
    end
    bus4.req = 8'h00;
    @(negedge clk);
    chk("mux_off", {31'd0, bus4.sel_valid}, 32'd0);

    // Random traffic with sticky request bits.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 5) == 0) bus4.req[i] = ~bus4.req[i];
        if ($urandom_range(0, 5) == 0) bus1.req[i] = ~bus1.req[i];
      end
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux among 8 requesters.
- Drives the mux select S[2:0] with a registered index and issues a one-hot grant to the requester whose input is currently routed to Y.
- Limits each owner to MAX_HOLD consecutive cycles while others wait, so no requester starves.
- Sits in front of mux_8_1; requester i owns mux input Ii.

Parameters:
- N, 8, number of requesters / mux inputs; fixed at 8 for this build.
- SEL_W, 3, select width, log2(N).
- MAX_HOLD, 4, max consecutive grant cycles for one owner while another requester is pending; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i wants the mux.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  mux select to mux_8_1 S, registered; equals index of the set gnt bit while sel_valid=1.
- sel_valid  output  1  registered; 1 while a grant is active (Y is meaningful).

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Internal state:
  - state: IDLE or GRANT.
  - ptr[2:0]: priority start index.
  - owner[2:0].
  - hold_cnt[3:0].
- Reset (asserted at any time, including mid-grant): gnt=8'h00, sel=3'd0, sel_valid=0, state=IDLE, ptr=0, hold_cnt=0. Takes effect immediately, without waiting for a clock edge.
- Arbitration function pick(req, start):
  - Returns the first set bit scanning start, start+1, ... start+7, modulo 8.
  - Pure combinational; feeds registered outputs only.
- Latency: a request seen at edge t produces gnt/sel/sel_valid at edge t (visible after t). In other words, outputs change one cycle after req is presented.
- IDLE:
  - If req==0: stay in IDLE, outputs unchanged (gnt=0, sel_valid=0, sel holds last value).
  - Else: k=pick(req, ptr); owner=k; gnt=1<<k; sel=k; sel_valid=1; hold_cnt=1; go to GRANT.
- GRANT, owner k, evaluated every edge:
  - release = (req[k]==0).
  - preempt = (req[k]==1) && (hold_cnt>=MAX_HOLD) && ((req & ~(1<<k))!=0).
  - If neither: keep the grant; hold_cnt = min(hold_cnt+1, MAX_HOLD) (saturates).
  - If release or preempt:
    - ptr=k+1 mod 8 (7 wraps to 0).
    - Let r = req with bit k cleared.
    - If r!=0: j=pick(r, k+1); owner=j; gnt=1<<j; sel=j; hold_cnt=1; stay in GRANT. This is a back-to-back handover with no idle cycle.
    - If r==0: gnt=0, sel_valid=0, sel holds k, go to IDLE.
- Owner alone, hold expired: no preempt; grant persists indefinitely and hold_cnt stays at MAX_HOLD.
- Simultaneous release by the owner and new requests from others: the handover happens at the same edge.
- gnt is always one-hot or zero, never multi-hot.
- sel_valid==1 iff gnt!=0.
- All outputs come directly from flops; there are no combinational paths from req to outputs.
- MAX_HOLD=1: any pending competitor preempts the owner after one cycle, giving a pure rotating grant.

Decomposition:
- Shared package (mux8_arb_pkg) holds:
  - localparams N=8, SEL_W=3.
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Function onehot8(idx).
- One sub-module: rr_pick8. It is the combinational circular priority encoder:
  - Inputs: req[7:0], start[2:0].
  - Outputs: idx[2:0], any.
  - It is instantiated once; the arbiter muxes its inputs (req vs. req-minus-owner, ptr vs. owner+1) by state.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=00, sel_valid=0, sel=0 throughout. Assert rst_n=0 mid-grant (owner 3) -> gnt=00, sel_valid=0, sel=0 immediately, without waiting for a clock edge.
- Single request req=8'h04 held -> one cycle later gnt=8'h04, sel=2, sel_valid=1. Grant held for 10+ cycles (no competitor, hold saturates). Drop req -> next cycle gnt=00, sel_valid=0, sel stays 2.
- Preemption, MAX_HOLD=4: req=8'h81 continuously from reset -> grant sequence in cycles:
  - cycles 1-4: gnt=01, sel=0.
  - cycles 5-8: gnt=80, sel=7.
  - cycles 9-12: gnt=01, sel=0 (ptr wraps 7->0).
- Back-to-back handover: owner 5 drops req in the same cycle req[6] and req[1] rise -> next cycle gnt=8'h40, sel=6, sel_valid never deasserts.
- All request, req=8'hFF, MAX_HOLD=1 -> sel steps 0,1,2,...,7,0 one per cycle; gnt one-hot each cycle.
- Pair mux_8_1 with I5=1, others 0; req=8'h20 -> Y=1 exactly while sel_valid=1.
- Random req, 2000 cycles, checker:
  - gnt is one-hot or zero.
  - sel matches the gnt index.
  - No pending requester waits more than 7*MAX_HOLD+1 cycles.
